// File: rtl/reorder_buffer_mp.sv
// Multi-ported reorder buffer: in-order dispatch and retire, out-of-order tagged
// completion, plus a physical-register busy vector for issue wakeup.
module reorder_buffer_mp #(
  parameter int DEPTH  = 64,
  parameter int DISP_W = 2,
  parameter int CMPL_W = 4,
  parameter int RET_W  = 2,
  parameter int DATA_W = 32,
  parameter int PREG_W = 6,
  parameter int AREG_W = 5,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [DISP_W-1:0]                   disp_valid,
  input  logic [DISP_W-1:0][AREG_W-1:0]       disp_areg,
  input  logic [DISP_W-1:0][PREG_W-1:0]       disp_preg,
  input  logic [DISP_W-1:0][PREG_W-1:0]       disp_old_preg,
  input  logic [DISP_W-1:0]                   disp_is_store,
  input  logic [DISP_W-1:0][31:0]             disp_pc,
  output logic                                disp_ready,
  output logic [DISP_W-1:0][IDX_W-1:0]        disp_tag,
  input  logic [CMPL_W-1:0]                   cmpl_valid,
  input  logic [CMPL_W-1:0][IDX_W-1:0]        cmpl_tag,
  input  logic [CMPL_W-1:0][DATA_W-1:0]       cmpl_data,
  input  logic                                flush,
  output logic [RET_W-1:0]                    ret_valid,
  output logic [RET_W-1:0][AREG_W-1:0]        ret_areg,
  output logic [RET_W-1:0][PREG_W-1:0]        ret_preg,
  output logic [RET_W-1:0][PREG_W-1:0]        ret_old_preg,
  output logic [RET_W-1:0]                    ret_is_store,
  output logic [RET_W-1:0][DATA_W-1:0]        ret_data,
  output logic [RET_W-1:0][31:0]              ret_pc,
  output logic [(2**PREG_W)-1:0]              preg_busy,
  output logic [IDX_W:0]                      count,
  output logic                                empty,
  output logic                                full
);

  logic [IDX_W-1:0]  head;
  logic [IDX_W-1:0]  tail;
  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_done;
  logic [DEPTH-1:0]  ent_is_store;
  logic [AREG_W-1:0] ent_areg     [DEPTH];
  logic [PREG_W-1:0] ent_preg     [DEPTH];
  logic [PREG_W-1:0] ent_old_preg [DEPTH];
  logic [DATA_W-1:0] ent_data     [DEPTH];
  logic [31:0]       ent_pc       [DEPTH];

  logic [IDX_W:0]    n_disp_raw;
  logic [IDX_W:0]    n_disp;
  logic              disp_accept;
  logic [IDX_W:0]    n_ret;
  logic              ret_run;
  logic [RET_W-1:0]  ret_fire;
  logic [RET_W-1:0][IDX_W-1:0] ret_idx;
  logic [IDX_W:0]    free_slots;
  logic [IDX_W:0]    count_next;
  logic [(2**PREG_W)-1:0] busy_next;

  // Occupancy status depends only on the registered count, so an entry retired
  // this cycle cannot be re-allocated until the next one.
  assign free_slots  = (IDX_W+1)'(DEPTH) - count;
  assign disp_ready  = free_slots >= (IDX_W+1)'(DISP_W);
  assign empty       = count == '0;
  assign full        = count == (IDX_W+1)'(DEPTH);
  assign disp_accept = disp_ready && !flush;
  assign n_disp      = disp_accept ? n_disp_raw : '0;
  assign count_next  = count + n_disp - n_ret;

  // Valid lanes are packed onto consecutive entries; this is the one output
  // that has to look at disp_valid, since a lane's tag depends on the lanes below it.
  always_comb begin
    n_disp_raw = '0;
    for (int k = 0; k < DISP_W; k++) begin
      disp_tag[k] = tail + n_disp_raw[IDX_W-1:0];
      if (disp_valid[k]) n_disp_raw = n_disp_raw + (IDX_W+1)'(1);
    end
  end

  // Retire the leading run of valid+done entries starting at head.
  always_comb begin
    ret_fire = '0;
    n_ret    = '0;
    ret_run  = 1'b1;
    for (int i = 0; i < RET_W; i++) begin
      ret_idx[i] = head + IDX_W'(i);
      if (ret_run && ent_valid[ret_idx[i]] && ent_done[ret_idx[i]]) begin
        ret_fire[i] = 1'b1;
        n_ret       = n_ret + (IDX_W+1)'(1);
      end else begin
        ret_run = 1'b0;
      end
    end
  end

  // Completion clears come first so a same-cycle dispatch set of that preg wins.
  always_comb begin
    busy_next = preg_busy;
    for (int c = 0; c < CMPL_W; c++) begin
      if (cmpl_valid[c] && ent_valid[cmpl_tag[c]] && !ent_is_store[cmpl_tag[c]])
        busy_next[ent_preg[cmpl_tag[c]]] = 1'b0;
    end
    if (disp_accept) begin
      for (int k = 0; k < DISP_W; k++) begin
        if (disp_valid[k] && !disp_is_store[k] && disp_areg[k] != '0)
          busy_next[disp_preg[k]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ent_valid    <= '0;
      ent_done     <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      preg_busy    <= '0;
      ret_valid    <= '0;
      ret_areg     <= '0;
      ret_preg     <= '0;
      ret_old_preg <= '0;
      ret_is_store <= '0;
      ret_data     <= '0;
      ret_pc       <= '0;
    end else if (flush) begin
      ent_valid <= '0;
      ent_done  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      preg_busy <= '0;
      ret_valid <= '0;
    end else begin
      // Later lanes overwrite earlier ones, so the highest lane wins on a tag clash.
      for (int c = 0; c < CMPL_W; c++) begin
        if (cmpl_valid[c] && ent_valid[cmpl_tag[c]]) ent_done[cmpl_tag[c]] <= 1'b1;
      end
      for (int r = 0; r < RET_W; r++) begin
        if (ret_fire[r]) begin
          ent_valid[ret_idx[r]] <= 1'b0;
          ret_areg[r]           <= ent_areg[ret_idx[r]];
          ret_preg[r]           <= ent_is_store[ret_idx[r]] ? '0 : ent_preg[ret_idx[r]];
          ret_old_preg[r]       <= ent_is_store[ret_idx[r]] ? '0 : ent_old_preg[ret_idx[r]];
          ret_is_store[r]       <= ent_is_store[ret_idx[r]];
          ret_data[r]           <= ent_data[ret_idx[r]];
          ret_pc[r]             <= ent_pc[ret_idx[r]];
        end else begin
          ret_areg[r]     <= '0;
          ret_preg[r]     <= '0;
          ret_old_preg[r] <= '0;
          ret_is_store[r] <= 1'b0;
          ret_data[r]     <= '0;
          ret_pc[r]       <= '0;
        end
      end
      if (disp_accept) begin
        for (int k = 0; k < DISP_W; k++) begin
          if (disp_valid[k]) begin
            ent_valid[disp_tag[k]] <= 1'b1;
            ent_done[disp_tag[k]]  <= 1'b0;
          end
        end
      end
      head      <= head + n_ret[IDX_W-1:0];
      tail      <= tail + n_disp[IDX_W-1:0];
      count     <= count_next;
      preg_busy <= busy_next;
      ret_valid <= ret_fire;
    end
  end

  // Payload storage carries no reset; entry valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (disp_accept) begin
      for (int k = 0; k < DISP_W; k++) begin
        if (disp_valid[k]) begin
          ent_areg[disp_tag[k]]     <= disp_areg[k];
          ent_preg[disp_tag[k]]     <= disp_preg[k];
          ent_old_preg[disp_tag[k]] <= disp_old_preg[k];
          ent_is_store[disp_tag[k]] <= disp_is_store[k];
          ent_pc[disp_tag[k]]       <= disp_pc[k];
        end
      end
    end
    if (!flush) begin
      for (int c = 0; c < CMPL_W; c++) begin
        if (cmpl_valid[c] && ent_valid[cmpl_tag[c]]) ent_data[cmpl_tag[c]] <= cmpl_data[c];
      end
    end
  end

endmodule
